// File: rtl/sysid_reader.sv
// sysid_reader
// Avalon-MM read master that fetches the system ID word (BASE_ADDR+0) and the
// build timestamp word (BASE_ADDR+4) from the sysid slave and compares them
// against the values this firmware build expects. The check runs once after
// reset when AUTO_START is set and can be rerun with a start pulse.
//
// Optional feature macro: SYSID_READER_TIMEOUT_EN
//   When defined, a per-read watchdog of TIMEOUT_CYCLES cycles moves the block
//   to an ERROR state if the slave never accepts or never answers a read.
//   When undefined, the block waits indefinitely and 'error' is tied low.
//
// Ports
//   clk                clock, all logic on the rising edge
//   reset              asynchronous active-high reset
//   start              one-cycle request to run or rerun the check
//   avm_address        registered byte address of the current read
//   avm_read           registered read request
//   avm_waitrequest    slave stall
//   avm_readdata       read data
//   avm_readdatavalid  read response strobe
//   busy               sequence in progress
//   done               sequence finished, held until the next start
//   id_ok / ts_ok      captured words equal the expected values
//   error              watchdog expired
//   id_value/ts_value  last captured ID and timestamp words

module sysid_reader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] EXPECTED_ID    = 32'd17734393,
  parameter logic [31:0] EXPECTED_TS    = 32'd1318966812,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [31:0] ID_ADDR = BASE_ADDR;
  localparam logic [31:0] TS_ADDR = BASE_ADDR + 32'd4;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_reader: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    DONE,
    ERROR
  } state_t;

  state_t      state, state_n;
  logic        auto_pending, auto_n;
  logic        read_n, busy_n, done_n, id_ok_n, ts_ok_n;
  logic [31:0] addr_n, id_value_n, ts_value_n;
  logic        in_seq;
  logic        rsp_event;

  // A response only counts while one of the WAIT states is actually waiting.
  assign in_seq    = (state == RD_ID) || (state == WAIT_ID) ||
                     (state == RD_TS) || (state == WAIT_TS);
  assign rsp_event = ((state == WAIT_ID) || (state == WAIT_TS)) && avm_readdatavalid;

`ifdef SYSID_READER_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt, cnt_n;
  logic        err_q, err_n;

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // State and every output are registered together; the combinational block
  // below only decides their next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
      avm_read     <= 1'b0;
      avm_address  <= ID_ADDR;
      busy         <= 1'b0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
`ifdef SYSID_READER_TIMEOUT_EN
      cnt          <= 16'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      auto_pending <= auto_n;
      avm_read     <= read_n;
      avm_address  <= addr_n;
      busy         <= busy_n;
      done         <= done_n;
      id_ok        <= id_ok_n;
      ts_ok        <= ts_ok_n;
      id_value     <= id_value_n;
      ts_value     <= ts_value_n;
`ifdef SYSID_READER_TIMEOUT_EN
      cnt          <= cnt_n;
      err_q        <= err_n;
`endif
    end
  end

  // Next-state and next-output logic. The start edge only arms the sequence;
  // the ID read is raised on the following edge. The timestamp read is raised
  // on the same edge that captures the ID response, so the two reads are not
  // symmetric in latency.
  always_comb begin
    state_n    = state;
    auto_n     = auto_pending;
    read_n     = avm_read;
    addr_n     = avm_address;
    busy_n     = busy;
    done_n     = done;
    id_ok_n    = id_ok;
    ts_ok_n    = ts_ok;
    id_value_n = id_value;
    ts_value_n = ts_value;
`ifdef SYSID_READER_TIMEOUT_EN
    cnt_n      = cnt;
    err_n      = err_q;
`endif

    case (state)
      IDLE, DONE, ERROR: begin
        if (start || auto_pending) begin
          state_n = RD_ID;
          auto_n  = 1'b0;
          read_n  = 1'b0;
          addr_n  = ID_ADDR;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          id_ok_n = 1'b0;
          ts_ok_n = 1'b0;
`ifdef SYSID_READER_TIMEOUT_EN
          cnt_n   = 16'd0;
          err_n   = 1'b0;
`endif
        end
      end

      RD_ID: begin
        if (!avm_read) begin
          read_n = 1'b1;
        end else if (!avm_waitrequest) begin
          read_n  = 1'b0;
          state_n = WAIT_ID;
        end
      end

      WAIT_ID: begin
        if (avm_readdatavalid) begin
          id_value_n = avm_readdata;
          id_ok_n    = (avm_readdata == EXPECTED_ID);
          state_n    = RD_TS;
          read_n     = 1'b1;
          addr_n     = TS_ADDR;
`ifdef SYSID_READER_TIMEOUT_EN
          cnt_n      = 16'd0;
`endif
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          read_n  = 1'b0;
          state_n = WAIT_TS;
        end
      end

      WAIT_TS: begin
        if (avm_readdatavalid) begin
          ts_value_n = avm_readdata;
          ts_ok_n    = (avm_readdata == EXPECTED_TS);
          state_n    = DONE;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          addr_n     = ID_ADDR;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef SYSID_READER_TIMEOUT_EN
    // A response arriving on the last allowed cycle still wins over the
    // watchdog; otherwise the count runs through both RD and WAIT cycles.
    if (in_seq && !rsp_event) begin
      if (cnt == LIMIT) begin
        state_n = ERROR;
        read_n  = 1'b0;
        addr_n  = ID_ADDR;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        err_n   = 1'b1;
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_sysid_reader.sv
// tb_sysid_reader
// Directed bench for sysid_reader. A small Avalon slave model answers reads
// with a programmable number of waitrequest cycles and response latency.
// Each table row reruns the auto-start sequence from reset and checks the
// edge on which done rises plus the captured words and match flags.
// Define SYSID_READER_TIMEOUT_EN to also exercise the watchdog (limit 8).

module tb_sysid_reader;

  localparam logic [31:0] BASE   = 32'h0;
  localparam logic [31:0] EXP_ID = 32'd17734393;
  localparam logic [31:0] EXP_TS = 32'd1318966812;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, id_ok, ts_ok, error;
  logic [31:0] id_value, ts_value;

  int errors = 0;
  int checks = 0;

  // Slave model configuration, written only by the main process
  logic [31:0] cfg_id;
  logic [31:0] cfg_ts;
  int          cfg_wait;
  int          cfg_lat;
  bit          respond_en;
  int          inject_req;

  // Slave model state, written only by the slave process
  int          stall;
  int          pend;
  logic [31:0] pend_data;
  bit          stalled_prev;
  logic [31:0] prev_addr;
  int          stall_obs;
  int          stall_viol;
  int          read_count;
  logic [31:0] addr_log [0:255];
  int          inject_seen;

  sysid_reader #(
    .BASE_ADDR      (BASE),
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .AUTO_START     (1'b1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .error             (error),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: updates its outputs on the falling edge so the DUT samples
  // them on the next rising edge. A read is accepted on the rising edge that
  // follows the falling edge where waitrequest is dropped while avm_read is
  // high; the response strobe then lands cfg_lat rising edges later.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0 && respond_en) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_data;
      end
    end
    if (inject_req != inject_seen) begin
      inject_seen       = inject_req;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEADBEEF;
    end
    if (stalled_prev && !reset) begin
      stall_obs = stall_obs + 1;
      if (!avm_read || avm_address != prev_addr) stall_viol = stall_viol + 1;
    end
    stalled_prev = 1'b0;
    if (avm_read && !reset) begin
      if (stall < cfg_wait) begin
        avm_waitrequest = 1'b1;
        stall           = stall + 1;
        stalled_prev    = 1'b1;
        prev_addr       = avm_address;
      end else begin
        avm_waitrequest = 1'b0;
        stall           = 0;
        pend            = cfg_lat;
        pend_data       = (avm_address == BASE) ? cfg_id : cfg_ts;
        if (read_count < 256) addr_log[read_count] = avm_address;
        read_count      = read_count + 1;
      end
    end else begin
      avm_waitrequest = 1'b0;
      stall           = 0;
    end
  end

  typedef struct {
    logic [31:0] id_data;
    logic [31:0] ts_data;
    int          waitc;
    int          lat;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    int          exp_edge;
  } vec_t;

  vec_t vecs [5];

  // One comparison; every failure prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulse start for one rising edge; returns at the falling edge after it.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Hold reset across a falling edge and release it mid-cycle, so the next
  // rising edge is edge 0 of the auto-started sequence.
  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Count rising edges (edge 0 first) until done is seen just after an edge.
  task automatic runUntilDone(output int edge_n);
    edge_n = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edge_n = n;
        break;
      end
    end
  endtask

  task automatic waitDoneNeg(input string name);
    int seen;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int e;
    int rc0;

    vecs[0] = '{EXP_ID, EXP_TS,        0, 1, 1'b1, 1'b1, 5};
    vecs[1] = '{32'h0,  EXP_TS,        0, 1, 1'b0, 1'b1, 5};
    vecs[2] = '{EXP_ID, EXP_TS,        2, 2, 1'b1, 1'b1, 11};
    vecs[3] = '{EXP_ID, 32'h12345678,  1, 1, 1'b1, 1'b0, 7};
    vecs[4] = '{32'hCAFE0001, 32'h0,   0, 3, 1'b0, 1'b0, 9};

    start = 1'b0;
    reset = 1'b1;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_wait = 0; cfg_lat = 1;
    respond_en = 1'b1; inject_req = 0;
    stall = 0; pend = 0; pend_data = 0; stalled_prev = 1'b0; prev_addr = 0;
    stall_obs = 0; stall_viol = 0; read_count = 0; inject_seen = 0;

    // Reset state
    #12;
    checkOutput("rst_avm_read", 32'(avm_read), 32'd0);
    checkOutput("rst_address", avm_address, BASE);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_id_ok", 32'(id_ok), 32'd0);
    checkOutput("rst_ts_ok", 32'(ts_ok), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_id_value", id_value, 32'd0);
    checkOutput("rst_ts_value", ts_value, 32'd0);

    // Table-driven auto-start runs
    for (int i = 0; i < 5; i++) begin
      cfg_id   = vecs[i].id_data;
      cfg_ts   = vecs[i].ts_data;
      cfg_wait = vecs[i].waitc;
      cfg_lat  = vecs[i].lat;
      rc0      = read_count;
      applyReset();
      runUntilDone(e);
      $display("[TB] vector %0d done at edge %0d", i, e);
      checkOutput($sformatf("v%0d_done_edge", i), 32'(e), 32'(vecs[i].exp_edge));
      checkOutput($sformatf("v%0d_id_ok", i), 32'(id_ok), 32'(vecs[i].exp_id_ok));
      checkOutput($sformatf("v%0d_ts_ok", i), 32'(ts_ok), 32'(vecs[i].exp_ts_ok));
      checkOutput($sformatf("v%0d_id_value", i), id_value, vecs[i].id_data);
      checkOutput($sformatf("v%0d_ts_value", i), ts_value, vecs[i].ts_data);
      checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d_error", i), 32'(error), 32'd0);
      checkOutput($sformatf("v%0d_idle_addr", i), avm_address, BASE);
      checkOutput($sformatf("v%0d_reads", i), 32'(read_count - rc0), 32'd2);
      checkOutput($sformatf("v%0d_addr0", i), addr_log[rc0 & 255], BASE);
      checkOutput($sformatf("v%0d_addr1", i), addr_log[(rc0 + 1) & 255], BASE + 32'd4);
    end

    checkOutput("stall_cycles_seen", 32'(stall_obs > 0), 32'd1);
    checkOutput("stall_hold_violations", 32'(stall_viol), 32'd0);

    // start while busy is ignored; start in DONE reruns
    cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_wait = 0; cfg_lat = 1;
    rc0 = read_count;
    applyStimulus();
    checkOutput("restart_done_cleared", 32'(done), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_start_ignored_addr", avm_address, BASE + 32'd4);
    checkOutput("busy_start_ignored_read", 32'(avm_read), 32'd1);
    waitDoneNeg("restart1_done");
    applyStimulus();
    checkOutput("restart2_done_cleared", 32'(done), 32'd0);
    waitDoneNeg("restart2_done");
    repeat (10) @(negedge clk);
    checkOutput("restart_total_reads", 32'(read_count - rc0), 32'd4);
    checkOutput("restart_id_ok", 32'(id_ok), 32'd1);
    checkOutput("restart_ts_ok", 32'(ts_ok), 32'd1);

    // Reset while a read is stalled drops avm_read at once
    cfg_wait = 20;
    applyReset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("stall_rst_avm_read", 32'(avm_read), 32'd0);
    checkOutput("stall_rst_busy", 32'(busy), 32'd0);

    // Reset in WAIT_TS, then the auto rerun completes
    cfg_wait = 0;
    cfg_lat  = 3;
    applyReset();
    repeat (7) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("wts_rst_busy", 32'(busy), 32'd0);
    checkOutput("wts_rst_done", 32'(done), 32'd0);
    checkOutput("wts_rst_avm_read", 32'(avm_read), 32'd0);
    checkOutput("wts_rst_id_value", id_value, 32'd0);
    checkOutput("wts_rst_id_ok", 32'(id_ok), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    runUntilDone(e);
    checkOutput("wts_rerun_done_edge", 32'(e), 32'd9);
    checkOutput("wts_rerun_id_ok", 32'(id_ok), 32'd1);
    checkOutput("wts_rerun_ts_ok", 32'(ts_ok), 32'd1);

`ifdef SYSID_READER_TIMEOUT_EN
    // Watchdog: no response to the ID read
    cfg_wait   = 0;
    cfg_lat    = 1;
    respond_en = 1'b0;
    applyReset();
    runUntilDone(e);
    checkOutput("to_edge", 32'(e), 32'd8);
    checkOutput("to_error", 32'(error), 32'd1);
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_avm_read", 32'(avm_read), 32'd0);
    inject_req = inject_req + 1;
    repeat (3) @(negedge clk);
    checkOutput("to_late_id_value", id_value, 32'd0);
    checkOutput("to_late_id_ok", 32'(id_ok), 32'd0);
    checkOutput("to_still_error", 32'(error), 32'd1);
    respond_en = 1'b1;
    applyStimulus();
    checkOutput("to_restart_error_cleared", 32'(error), 32'd0);
    waitDoneNeg("to_restart_done");
    checkOutput("to_restart_id_ok", 32'(id_ok), 32'd1);
    checkOutput("to_restart_ts_ok", 32'(ts_ok), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
